// File: rtl/osc_voice_sequencer_if.sv
// Configuration bus for the voice sequencer: per-voice frequency and wave-select writes.
interface osc_voice_sequencer_if #(
  parameter int unsigned NumVoices = 4
);
  localparam int unsigned AddrW = $clog2(NumVoices);

  logic             cfg_we;
  logic [AddrW-1:0] cfg_addr;
  logic [15:0]      cfg_freq;
  logic [1:0]       cfg_wave;

  modport master (output cfg_we, cfg_addr, cfg_freq, cfg_wave);
  modport slave  (input  cfg_we, cfg_addr, cfg_freq, cfg_wave);
endinterface

// File: rtl/osc_voice_sequencer.sv
// Oscillator voice sequencer: each sample tick steps every voice once through a shared,
// one-cycle-latency saw->triangle shaper and emits the averaged, signed mix of all voices.
module osc_voice_sequencer #(
  parameter int unsigned NumVoices = 4,
  parameter int unsigned PhaseW    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  locked_i,
  input  logic                  sample_tick_i,
  osc_voice_sequencer_if.slave  cfg_if,
  output logic [PhaseW-1:0]     shp_saw_o,
  input  logic [PhaseW-1:0]     shp_out_i,
  output logic [PhaseW-1:0]     mix_o,
  output logic                  mix_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int unsigned VoiceW = $clog2(NumVoices);
  localparam int unsigned AccW   = PhaseW + VoiceW;
  localparam logic [VoiceW-1:0] LastVoice = VoiceW'(NumVoices - 1);
  localparam logic [PhaseW-1:0] SignFlip  = PhaseW'(1) << (PhaseW - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  // Per-voice state
  logic [PhaseW-1:0] phase_q [NumVoices];
  logic [PhaseW-1:0] freq_q  [NumVoices];
  logic [1:0]        wave_q  [NumVoices];

  // Sequencer state
  state_e             state_q;
  logic [VoiceW-1:0]  cnt_q;
  logic               busy_q;
  logic               mix_valid_q;
  logic [PhaseW-1:0]  mix_q;
  logic signed [AccW-1:0] acc_q;

  // Issue stage (shaper input) and collect stage (shaper output valid)
  logic [PhaseW-1:0] shp_saw_q;
  logic              s0_valid_q;
  logic [1:0]        s0_wave_q;
  logic              s1_valid_q;
  logic [1:0]        s1_wave_q;
  logic [PhaseW-1:0] s1_phase_q;

  logic                   start;
  logic                   issue_en;
  logic [VoiceW-1:0]      issue_idx;
  logic [PhaseW-1:0]      raw;
  logic signed [PhaseW-1:0] contrib16;
  logic signed [AccW-1:0] contrib;
  logic signed [AccW-1:0] acc_sum;

  // Voice 0 is issued on the tick edge itself so its phase is on the shaper in cycle 1.
  always_comb begin
    start     = (state_q == StIdle) && sample_tick_i && locked_i;
    issue_en  = start || ((state_q == StIssue) && (cnt_q != LastVoice));
    issue_idx = start ? '0 : cnt_q + VoiceW'(1);
  end

  // Collect: pick the raw waveform for the voice whose shaper result is valid now.
  always_comb begin
    raw = '0;
    unique case (s1_wave_q)
      2'd0:    raw = '0;
      2'd1:    raw = s1_phase_q;
      2'd2:    raw = shp_out_i;
      default: raw = {PhaseW{s1_phase_q[PhaseW-1]}};
    endcase
    contrib16 = raw ^ SignFlip;
    // Off voices must contribute exactly zero, not the offset-binary midpoint.
    if (s1_valid_q && (s1_wave_q != 2'd0)) begin
      contrib = {{VoiceW{contrib16[PhaseW-1]}}, contrib16};
    end else begin
      contrib = '0;
    end
    acc_sum = acc_q + contrib;
  end

  // Config writes land immediately; an issue in the same cycle still sees the old values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      freq_q <= '{default: '0};
      wave_q <= '{default: '0};
    end else if (cfg_if.cfg_we) begin
      freq_q[cfg_if.cfg_addr] <= cfg_if.cfg_freq;
      wave_q[cfg_if.cfg_addr] <= cfg_if.cfg_wave;
    end
  end

  // Phase accumulators advance once per frame, when their voice is issued (wraps mod 2^PhaseW).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '{default: '0};
    end else if (issue_en) begin
      phase_q[issue_idx] <= phase_q[issue_idx] + freq_q[issue_idx];
    end
  end

  // Issue/collect pipeline: wave and phase travel alongside the shaper's one-cycle latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shp_saw_q  <= '0;
      s0_valid_q <= 1'b0;
      s0_wave_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_wave_q  <= '0;
      s1_phase_q <= '0;
    end else begin
      if (issue_en) begin
        shp_saw_q <= phase_q[issue_idx];
        s0_wave_q <= wave_q[issue_idx];
      end
      s0_valid_q <= issue_en;
      s1_valid_q <= s0_valid_q;
      s1_wave_q  <= s0_wave_q;
      s1_phase_q <= shp_saw_q;
    end
  end

  // Frame FSM: IDLE -> ISSUE (one cycle per voice) -> DRAIN -> DONE -> IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mix_valid_q <= 1'b0;
      mix_q       <= '0;
      acc_q       <= '0;
    end else begin
      mix_valid_q <= 1'b0;
      if (start) begin
        acc_q <= '0;
      end else if (s1_valid_q) begin
        acc_q <= acc_sum;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StIssue: begin
          if (cnt_q == LastVoice) begin
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + VoiceW'(1);
          end
        end
        StDrain: begin
          // Last voice is collected this cycle; dropping the low VoiceW bits is the >>> VoiceW.
          state_q     <= StDone;
          mix_q       <= acc_sum[AccW-1:VoiceW];
          mix_valid_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign shp_saw_o   = shp_saw_q;
  assign mix_o       = mix_q;
  assign mix_valid_o = mix_valid_q;
  assign busy_o      = busy_q;
  assign overrun_o   = sample_tick_i && locked_i && busy_q;

endmodule

// File: tb/tb_osc_voice_sequencer.sv
// Bench for osc_voice_sequencer: directed scenarios plus randomized frames against a
// frame-level reference model (per-voice phase/freq/wave arrays, integer mix arithmetic).
module tb_osc_voice_sequencer;
  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] shp_saw;
  logic [15:0] shp_out = 16'h0000;
  logic [15:0] mix;
  logic        mix_valid;
  logic        busy;
  logic        overrun;

  int stub_mode = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_phase [N];
  logic [15:0] m_freq  [N];
  logic [1:0]  m_wave  [N];

  osc_voice_sequencer_if #(.NumVoices(N)) cfg_if ();

  osc_voice_sequencer #(.NumVoices(N), .PhaseW(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .locked_i      (locked),
    .sample_tick_i (tick),
    .cfg_if        (cfg_if.slave),
    .shp_saw_o     (shp_saw),
    .shp_out_i     (shp_out),
    .mix_o         (mix),
    .mix_valid_o   (mix_valid),
    .busy_o        (busy),
    .overrun_o     (overrun)
  );

  always #5 clk = ~clk;

  // Shaper stub: mode 0 returns a constant, mode 1 a true triangle of the phase.
  function automatic logic [15:0] stub_f(input logic [15:0] x);
    if (stub_mode == 0) return 16'hC000;
    return x[15] ? ~{x[14:0], 1'b0} : {x[14:0], 1'b0};
  endfunction

  always @(posedge clk) shp_out <= stub_f(shp_saw);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int contrib(input logic [1:0] w, input logic [15:0] ph);
    logic [15:0]        raw;
    logic signed [15:0] s;
    case (w)
      2'd0:    return 0;
      2'd1:    raw = ph;
      2'd2:    raw = stub_f(ph);
      default: raw = ph[15] ? 16'hFFFF : 16'h0000;
    endcase
    s = raw ^ 16'h8000;
    return int'(s);
  endfunction

  task automatic model_clear();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = '0;
      m_freq[v]  = '0;
      m_wave[v]  = '0;
    end
  endtask

  // Reset held for 10 cycles, outputs checked while held; returns at posedge+1 after release.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    tick = 1'b0;
    cfg_if.cfg_we = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq({tag, "_mix"}, mix, 16'h0000);
    check_eq({tag, "_mix_valid"}, mix_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_shp_saw"}, shp_saw, 16'h0000);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int v, input logic [15:0] f, input logic [1:0] w);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_addr = 2'(v);
    cfg_if.cfg_freq = f;
    cfg_if.cfg_wave = w;
    @(posedge clk); #1;
    cfg_if.cfg_we = 1'b0;
    m_freq[v] = f;
    m_wave[v] = w;
  endtask

  // One frame: tick in cycle 0, cycles 0..7 checked. Optional config write in cycle wr_c
  // (wr_c < 0: none), extra tick in cycle 3, LOCKED dropped from cycle 2.
  task automatic run_frame(input int wr_c, input int wr_v, input logic [15:0] wr_f,
                           input logic [1:0] wr_w, input bit ovr, input bit drop_lock);
    logic [15:0] pre [N];
    logic [15:0] ef;
    logic [1:0]  ew;
    logic [15:0] exp_mix;
    int          sum;
    bit          nw;
    sum = 0;
    for (int v = 0; v < N; v++) begin
      // A write lands at the end of its cycle; voice v is read at the end of cycle v.
      nw = (wr_c >= 0) && (wr_v == v) && (wr_c < v);
      ef = nw ? wr_f : m_freq[v];
      ew = nw ? wr_w : m_wave[v];
      pre[v] = m_phase[v];
      sum += contrib(ew, pre[v]);
      m_phase[v] = pre[v] + ef;
    end
    exp_mix = 16'(sum >>> 2);
    if (wr_c >= 0) begin
      m_freq[wr_v] = wr_f;
      m_wave[wr_v] = wr_w;
    end
    for (int k = 0; k < 8; k++) begin
      tick = (k == 0) || (ovr && k == 3);
      if (k == wr_c) begin
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_addr = 2'(wr_v);
        cfg_if.cfg_freq = wr_f;
        cfg_if.cfg_wave = wr_w;
      end else begin
        cfg_if.cfg_we = 1'b0;
      end
      if (drop_lock && k == 2) locked = 1'b0;
      #1;
      check_eq($sformatf("busy_c%0d", k), busy, (k >= 1 && k <= 6));
      check_eq($sformatf("mix_valid_c%0d", k), mix_valid, (k == 6));
      check_eq($sformatf("overrun_c%0d", k), overrun, (ovr && !drop_lock && k == 3));
      if (k >= 1 && k <= 4) check_eq($sformatf("shp_saw_v%0d", k - 1), shp_saw, pre[k-1]);
      if (k == 6) check_eq("mix", mix, exp_mix);
      @(posedge clk); #1;
    end
    tick = 1'b0;
    cfg_if.cfg_we = 1'b0;
    locked = 1'b1;
  endtask

  initial begin
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_addr = '0;
    cfg_if.cfg_freq = '0;
    cfg_if.cfg_wave = '0;
    model_clear();

    // Reset values
    do_reset("rst");

    // Single saw voice, two frames
    cfg_write(0, 16'h1000, 2'd1);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    check_eq("saw_f1", mix, 16'hE000);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    check_eq("saw_f2", mix, 16'hE400);

    // Triangle via shaper stub
    do_reset("rst_tri");
    cfg_write(0, 16'h0000, 2'd2);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    check_eq("tri_mix", mix, 16'h1000);

    // All voices square: negative full scale, then positive full scale
    do_reset("rst_sq");
    for (int v = 0; v < N; v++) cfg_write(v, 16'h0000, 2'd3);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    check_eq("sq_low", mix, 16'h8000);
    for (int v = 0; v < N; v++) cfg_write(v, 16'h8000, 2'd3);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    check_eq("sq_high", mix, 16'h7FFF);

    // Overrun: second tick mid-frame is ignored
    run_frame(-1, 0, 16'h0, 2'd0, 1'b1, 1'b0);

    // Same-cycle write and issue of voice 1: old values this frame
    run_frame(1, 1, 16'h0123, 2'd1, 1'b0, 1'b0);

    // LOCKED low: tick ignored, no overrun
    locked = 1'b0;
    tick = 1'b1;
    #1;
    check_eq("unlocked_overrun", overrun, 0);
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) begin
      check_eq("unlocked_busy", busy, 0);
      @(posedge clk); #1;
    end
    locked = 1'b1;

    // Reset mid-frame aborts with no MIX_VALID
    do_reset("rst_abort_pre");
    cfg_write(0, 16'h1000, 2'd1);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_mix", mix, 16'h0000);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_shp_saw", shp_saw, 16'h0000);
    check_eq("abort_mix_valid", mix_valid, 0);
    repeat (6) begin
      @(posedge clk); #1;
      check_eq("abort_no_valid", mix_valid, 0);
    end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    cfg_write(0, 16'h1000, 2'd1);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    check_eq("post_abort_mix", mix, 16'hE000);

    // Phase wrap: 0xF000 + 0x2000 -> 0x1000
    do_reset("rst_wrap");
    cfg_write(0, 16'hF000, 2'd1);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    cfg_write(0, 16'h2000, 2'd1);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);
    run_frame(-1, 0, 16'h0, 2'd0, 1'b0, 1'b0);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      int nwr;
      int wc;
      stub_mode = int'($urandom_range(0, 1));
      nwr = int'($urandom_range(0, 3));
      for (int j = 0; j < nwr; j++) begin
        cfg_write(int'($urandom_range(0, N - 1)), 16'($urandom), 2'($urandom));
      end
      wc = int'($urandom_range(0, 9));
      run_frame((wc < 7) ? wc : -1, int'($urandom_range(0, N - 1)), 16'($urandom),
                2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
